ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//   Shares the single-port 8-bit program/data RAM between two requesters: port 0 (nanoprocessor
//   bus) and port 1 (loader/debug master). Arbitrates once per cycle and muxes address, write
//   data and write enable to the RAM. Returns read data one cycle later with a per-port valid.
//   Sits between the requesters and the RAM. A requester that is denied must hold its request
//   (the CPU stalls its clock enable).
// PARAMETERS
//   ADDR_W     8    RAM address width
//   DATA_W     8    RAM data width
//   MAX_BURST  4    max consecutive grants to one port while the other is requesting (>=1)
//   CNT_W      16   width of the conflict counter
// PORTS
//   clk             in   1       system clock, all logic on rising edge
//   reset           in   1       synchronous reset, active high
//   req0, req1      in   1       access request, port 0 / port 1
//   we0, we1        in   1       1 = write, 0 = read (qualified by req)
//   addr0, addr1    in   ADDR_W  access address
//   wdata0, wdata1  in   DATA_W  write data
//   lock0, lock1    in   1       hold ownership after this access (see CONFIGURATION)
//   gnt0, gnt1      out  1       combinational: access issued this cycle
//   rvalid0, rvalid1 out 1       registered: rdata holds the port's read result
//   rdata           out  DATA_W  read data, valid when rvalid0 or rvalid1 is set
//   ram_write       out  1       RAM write enable
//   ram_addr        out  ADDR_W  RAM address
//   ram_data_write  out  DATA_W  RAM write data
//   ram_data_read   in   DATA_W  RAM read data, synchronous, valid the cycle after the address
//   conflict_cnt    out  CNT_W   count of cycles in which a requester was denied, saturating
// BEHAVIOUR
//   - State: last (winner of the most recent granted cycle), burst (1..MAX_BURST, saturating),
//     and rvalid pipeline registers. Reset: last=0, burst=0, rvalid0/1=0, conflict_cnt=0.
//   - Winner each cycle:
//     - No req: no gnt, ram_write=0, ram_addr=addr0, burst<=0, last unchanged.
//     - One req: that port wins.
//     - Both req: last wins if burst<MAX_BURST, else the other port wins.
//   - At most one gnt per cycle. gnt never asserts without the matching req.
//   - Burst update: burst<=min(burst+1,MAX_BURST) if winner==last, else burst<=1; last<=winner.
//   - ram_write=gnt&we of the winner; ram_addr/ram_data_write come from the winner. Pure mux,
//     no added latency.
//   - Read latency 1: rvalidN<=gntN&~weN; rdata=ram_data_read (pass-through, qualified by rvalid).
//   - Write: no response. A write followed by a read of the same address returns the new data.
//   - conflict_cnt +1 in each cycle where both req are set. Saturates at 2^CNT_W-1.
//   - reset mid-access: the access in the reset cycle is dropped, so no rvalid follows it.
//     Outputs are at reset values the next cycle.
//   - Requesters may change addr/we/wdata freely while not granted.
// CONFIGURATION
//   RAM_ARB_LOCK_EN defined:
//     - A locked grant (gntN&lockN) gives port N the next cycle whenever reqN is set, ignoring
//       MAX_BURST. This supports atomic read-modify-write.
//     - The lock releases when the owner grants without lock or drops req.
//     - A locked grant still counts toward burst.
//   RAM_ARB_LOCK_EN undefined: lock0/lock1 are present but ignored. Arbitration is purely by
//     the burst rule.
// TESTING (MAX_BURST=4)
//   - Reset, then req0&req1 both reading, held for 10 cycles -> gnt pattern 0,0,0,0,1,1,1,1,0,0;
//     conflict_cnt=10.
//   - Port 1 writes 0xA5 @0x3C, then port 0 reads 0x3C -> rvalid0=1 one cycle after gnt0,
//     rdata=0xA5, rvalid1 stays 0.
//   - req0 alone for 6 cycles, then req1 joins -> gnt1 on the first joint cycle (burst=4 already).
//   - Both req; assert reset during a port-1 read grant -> next cycle rvalid1=0, gnt pattern
//     restarts with port 0.
//   - RAM_ARB_LOCK_EN: port 0 locked read @0x10, then unlocked write @0x10 while req1 is held
//     -> gnt0 on both cycles, then gnt1. Without the macro, the same stimulus follows the burst rule.
//   - conflict_cnt with CNT_W=4: 20 contended cycles -> saturates at 15, no wrap.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous single-port RAM between two requesters with a
// burst-limited fairness rule. Define RAM_ARB_LOCK_EN to let a locked grant keep ownership.
module ram_port_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_write,
  input  logic [DATA_W-1:0] ram_data_read,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic               last_q, last_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               rvalid0_q, rvalid0_d;
  logic               rvalid1_q, rvalid1_d;
  logic [CNT_W-1:0]   conflict_cnt_q, conflict_cnt_d;
  logic               win_valid_s, win_s, fair_win_s;

`ifdef RAM_ARB_LOCK_EN
  logic lock_act_q, lock_act_d;
  logic lock_port_q, lock_port_d;
`else
  logic lock_unused_s;
  assign lock_unused_s = lock0 ^ lock1;
`endif

  // Winner selection; an access presented during reset is never issued.
  always_comb begin
    win_valid_s = 1'b0;
    win_s       = 1'b0;
    fair_win_s  = (burst_q < BURST_LIM) ? last_q : ~last_q;
    case ({req1, req0})
      2'b01: begin
        win_valid_s = 1'b1;
        win_s       = 1'b0;
      end
      2'b10: begin
        win_valid_s = 1'b1;
        win_s       = 1'b1;
      end
      2'b11: begin
        win_valid_s = 1'b1;
`ifdef RAM_ARB_LOCK_EN
        win_s       = lock_act_q ? lock_port_q : fair_win_s;
`else
        win_s       = fair_win_s;
`endif
      end
      default: begin
        win_valid_s = 1'b0;
        win_s       = 1'b0;
      end
    endcase
    if (reset) begin
      win_valid_s = 1'b0;
    end else begin
      win_valid_s = win_valid_s;
    end
  end

  // RAM mux and port outputs; win_s is 0 when idle so the RAM sees port 0's address.
  always_comb begin
    gnt0           = win_valid_s & ~win_s;
    gnt1           = win_valid_s & win_s;
    ram_write      = win_valid_s & (win_s ? we1 : we0);
    ram_addr       = win_s ? addr1 : addr0;
    ram_data_write = win_s ? wdata1 : wdata0;
    rvalid0        = rvalid0_q;
    rvalid1        = rvalid1_q;
    rdata          = ram_data_read;
    conflict_cnt   = conflict_cnt_q;
  end

  // Next-state: burst history, read-response pipeline and saturating conflict count.
  always_comb begin
    last_d         = last_q;
    burst_d        = {BURST_W{1'b0}};
    rvalid0_d      = gnt0 & ~we0;
    rvalid1_d      = gnt1 & ~we1;
    conflict_cnt_d = conflict_cnt_q;
    if (win_valid_s) begin
      last_d = win_s;
      if (win_s == last_q) begin
        burst_d = (burst_q == BURST_LIM) ? BURST_LIM : burst_q + BURST_W'(1);
      end else begin
        burst_d = BURST_W'(1);
      end
    end else begin
      last_d  = last_q;
      burst_d = {BURST_W{1'b0}};
    end
    if (req0 && req1 && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

`ifdef RAM_ARB_LOCK_EN
  // Ownership is held only while the owner keeps winning with lock set.
  always_comb begin
    lock_act_d  = win_valid_s & (win_s ? lock1 : lock0);
    lock_port_d = win_s;
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_act_q  <= 1'b0;
      lock_port_q <= 1'b0;
    end else begin
      lock_act_q  <= lock_act_d;
      lock_port_q <= lock_port_d;
    end
  end
`endif

  // Arbiter state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q         <= 1'b0;
      burst_q        <= {BURST_W{1'b0}};
      rvalid0_q      <= 1'b0;
      rvalid1_q      <= 1'b0;
      conflict_cnt_q <= {CNT_W{1'b0}};
    end else begin
      last_q         <= last_d;
      burst_q        <= burst_d;
      rvalid0_q      <= rvalid0_d;
      rvalid1_q      <= rvalid1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus random traffic against a behavioural model
// with a bench-side RAM; honours RAM_ARB_LOCK_EN when defined.
module tb_ram_port_arbiter;

  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req0, req1, we0, we1, lock0, lock1;
  logic [7:0]  addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, ram_write;
  logic [7:0]  rdata, ram_addr, ram_data_write, ram_data_read;
  logic [15:0] conflict_cnt;
  logic        g0_b, g1_b, rv0_b, rv1_b, rw_b;
  logic [7:0]  rd_b, ra_b, rdw_b;
  logic [3:0]  conflict_cnt4;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_data_write(ram_data_write), .ram_data_read(ram_data_read),
    .conflict_cnt(conflict_cnt)
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAXB), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(g0_b), .gnt1(g1_b),
    .rvalid0(rv0_b), .rvalid1(rv1_b), .rdata(rd_b), .ram_write(rw_b),
    .ram_addr(ra_b), .ram_data_write(rdw_b), .ram_data_read(ram_data_read),
    .conflict_cnt(conflict_cnt4)
  );

  // Synchronous RAM driven by the main instance.
  logic [7:0] ram_mem [256];
  logic       tb_clear;
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
    end else if (ram_write) begin
      ram_mem[ram_addr] <= ram_data_write;
    end
    ram_data_read <= ram_mem[ram_addr];
  end

  int         n_checks, n_errors;
  logic [7:0] ref_mem [256];
  int         m_last, m_burst, m_conf, m_lock_port;
  bit         m_lock_act, e_rv0, e_rv1;
  logic [7:0] e_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_winner(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef RAM_ARB_LOCK_EN
    if (m_lock_act) return m_lock_port;
`endif
    return (m_burst < MAXB) ? m_last : 1 - m_last;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model to the next edge.
  task automatic tick(input bit rst, input bit r0, input bit r1, input bit w0, input bit w1,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input bit l0, input bit l1, output int win);
    logic [7:0] a;
    bit         wr;
    @(negedge clk);
    reset = rst; req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1; lock0 = l0; lock1 = l1;
    #1;
    check_eq("rvalid0", 32'(rvalid0), 32'(e_rv0));
    check_eq("rvalid1", 32'(rvalid1), 32'(e_rv1));
    if (e_rv0 || e_rv1) check_eq("rdata", 32'(rdata), 32'(e_rdata));
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'((m_conf > 65535) ? 65535 : m_conf));
    check_eq("conflict_cnt4", 32'(conflict_cnt4), 32'((m_conf > 15) ? 15 : m_conf));
    win = -1;
    if (rst) begin
      m_last = 0; m_burst = 0; m_conf = 0; m_lock_act = 1'b0; m_lock_port = 0;
      e_rv0 = 1'b0; e_rv1 = 1'b0;
    end else begin
      win = ref_winner(r0, r1);
      wr  = (win == 0) ? w0 : ((win == 1) ? w1 : 1'b0);
      a   = (win == 1) ? a1 : a0;
      check_eq("gnt0", 32'(gnt0), 32'(win == 0));
      check_eq("gnt1", 32'(gnt1), 32'(win == 1));
      check_eq("ram_write", 32'(ram_write), 32'(wr));
      check_eq("ram_addr", 32'(ram_addr), 32'(a));
      if (win >= 0) check_eq("ram_data_write", 32'(ram_data_write), 32'((win == 1) ? d1 : d0));
      e_rv0 = (win == 0) && !w0;
      e_rv1 = (win == 1) && !w1;
      if (win >= 0) begin
        if (wr) ref_mem[a] = (win == 1) ? d1 : d0;
        else e_rdata = ref_mem[a];
      end
      if (r0 && r1) m_conf++;
      if (win < 0) begin
        m_burst = 0;
      end else begin
        m_burst = (win == m_last) ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 1;
        m_last  = win;
      end
      m_lock_act  = (win >= 0) && ((win == 1) ? l1 : l0);
      m_lock_port = win;
    end
  endtask

  initial begin
    int w;
    int pat[10];
    int lpat[3];
    n_checks = 0; n_errors = 0;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00; lock0 = 1'b0; lock1 = 1'b0;
    tb_clear = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    m_last = 0; m_burst = 0; m_conf = 0; m_lock_act = 1'b0; m_lock_port = 0;
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rdata = 8'h00;

    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    tb_clear = 1'b0;
    check_eq("rst_rvalid0", 32'(rvalid0), 32'd0);
    check_eq("rst_rvalid1", 32'(rvalid1), 32'd0);
    check_eq("rst_conflict", 32'(conflict_cnt), 32'd0);

    // Both ports read continuously after reset.
    pat = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 8'(i + 32), 8'h00, 8'h00, 1'b0, 1'b0, w);
      check_eq("burst_pattern", 32'(w), 32'(pat[i]));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("conflict_10", 32'(conflict_cnt), 32'd10);

    // Port 1 writes, port 0 reads back the same address.
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 8'h00, 8'hA5, 1'b0, 1'b0, w);
    check_eq("wr_win", 32'(w), 32'd1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("rd_win", 32'(w), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("raw_rvalid0", 32'(rvalid0), 32'd1);
    check_eq("raw_rdata", 32'(rdata), 32'h0000_00A5);
    check_eq("raw_rvalid1", 32'(rvalid1), 32'd0);

    // Port 0 alone saturates its burst, so port 1 wins the first contended cycle.
    for (int i = 0; i < 6; i++)
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 64), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("join_win", 32'(w), 32'd1);

    // Reset lands on a port-1 read grant.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    for (int i = 0; i < 5; i++)
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 8'(i + 8), 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("pre_rst_win", 32'(w), 32'd1);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h0D, 8'h00, 8'h00, 1'b0, 1'b0, w);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h06, 8'h0E, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("post_rst_rvalid1", 32'(rvalid1), 32'd0);
    check_eq("post_rst_win", 32'(w), 32'd0);

    // Locked read-modify-write by port 0 while port 1 keeps requesting.
`ifdef RAM_ARB_LOCK_EN
    lpat = '{0, 0, 1};
`else
    lpat = '{0, 1, 1};
`endif
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    for (int i = 0; i < 3; i++)
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i + 16), 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0, w);
    check_eq("lock_rd_win", 32'(w), 32'(lpat[0]));
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h20, 8'h5A, 8'h00, 1'b0, 1'b0, w);
    check_eq("lock_wr_win", 32'(w), 32'(lpat[1]));
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h20, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("lock_after_win", 32'(w), 32'(lpat[2]));

    // Conflict counter saturation in the narrow-counter instance.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    for (int i = 0; i < 20; i++)
      tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'(i), 8'(i + 1), 8'h00, 8'h00, 1'b0, 1'b0, w);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);
    check_eq("sat_cnt4", 32'(conflict_cnt4), 32'd15);
    check_eq("sat_cnt16", 32'(conflict_cnt), 32'd20);

    // Random traffic on a small address window to exercise read-after-write.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
           8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, w);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
